// File: rtl/serial_sub_if.sv
// serial_sub_if: handshake and operand/result bundle for serial_sub_ctrl.
//   start       request, sampled by the controller only while idle
//   a, b        minuend / subtrahend, captured on the accepted start edge
//   busy        high while the operation is running
//   done        one-cycle pulse when the result becomes valid
//   diff        registered (a - b) mod 2^WIDTH
//   borrow_out  registered final borrow (1 when a < b, unsigned)
// master: requester side; slave: controller side.
interface serial_sub_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit unsigned subtractor.
// One full-subtract cell (two half-subtractor stages plus a registered
// borrow) is stepped over the operands LSB first, one bit per clock.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_sub_if slave: start/a/b in, busy/done/diff/borrow_out out
// Timing: accept at E0, busy for WIDTH cycles, done for one cycle at E_WIDTH,
// back to idle at E_(WIDTH+1). diff/borrow_out hold until the next result.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_sub_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nx;
    logic             bq;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    // one-bit subtract cell
    logic x, y, d1, b1, d, b2, bo;
    logic last;

    always_comb begin
        x  = sa[0];
        y  = sb[0];
        d1 = x ^ y;
        b1 = ~x & y;
        d  = d1 ^ bq;
        b2 = ~d1 & bq;
        bo = b1 | b2;
        // written as shift-then-insert so WIDTH=1 needs no special case
        sr_nx            = sr >> 1;
        sr_nx[WIDTH-1]   = d;
        last             = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            sr       <= '0;
            bq       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        bq  <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_nx;
                    bq  <= bo;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        diff_q   <= sr_nx;
                        borrow_q <= bo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: self-checking bench for serial_sub_ctrl with a WIDTH=8
// and a WIDTH=1 instance sharing one clock and reset. Expected results come
// from plain (WIDTH+1)-bit arithmetic: {borrow, diff} = a - b.
module tb_serial_sub_ctrl;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // last result each instance should be holding
    logic [7:0] pd8;
    logic       pb8;

    serial_sub_if #(.WIDTH(8)) b8 ();
    serial_sub_if #(.WIDTH(1)) b1 ();

    serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    serial_sub_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        b8.start = 1'b0; b8.a = '0; b8.b = '0;
        b1.start = 1'b0; b1.a = '0; b1.b = '0;
        #1;
        checks++;
        if ({b8.busy, b8.done, b8.diff, b8.borrow_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_w8 got %b want 0", {b8.busy, b8.done, b8.diff, b8.borrow_out});
        end
        checks++;
        if ({b1.busy, b1.done, b1.diff, b1.borrow_out} !== 4'd0) begin
            errors++;
            $display("FAIL reset_w1 got %b want 0", {b1.busy, b1.done, b1.diff, b1.borrow_out});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pd8 = '0;
        pb8 = 1'b0;
    endtask

    // One 8-bit operation. glitch_at >= 0 pulses start (a=3,b=1) for one
    // cycle at that busy sample, which must be ignored.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input int glitch_at, input string name);
        logic [8:0] r;
        int         busy_n, done_n, done_idx;
        bit         overlap, held;
        logic [7:0] got_d;
        logic       got_b;
        r = {1'b0, x} - {1'b0, y};
        busy_n = 0; done_n = 0; done_idx = -1; overlap = 0; held = 1;
        got_d = '0; got_b = 1'b0;
        @(negedge clk);
        b8.start = 1'b1; b8.a = x; b8.b = y;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (b8.busy) begin
                busy_n++;
                if (b8.diff !== pd8 || b8.borrow_out !== pb8) held = 0;
            end
            if (b8.done) begin
                done_n++;
                done_idx = i;
                got_d = b8.diff;
                got_b = b8.borrow_out;
            end
            if (b8.busy && b8.done) overlap = 1;
            if (i == 0) begin
                b8.start = 1'b0;
                b8.a = 8'($urandom);
                b8.b = 8'($urandom);
            end
            if (i == glitch_at) begin
                b8.start = 1'b1; b8.a = 8'd3; b8.b = 8'd1;
            end else if (glitch_at >= 0 && i == glitch_at + 1) begin
                b8.start = 1'b0;
            end
        end
        checks++;
        if (busy_n != 8) begin errors++; $display("FAIL %s busy_cycles got %0d want 8", name, busy_n); end
        checks++;
        if (done_n != 1) begin errors++; $display("FAIL %s done_count got %0d want 1", name, done_n); end
        checks++;
        if (done_idx != 8) begin errors++; $display("FAIL %s done_latency got %0d want 8", name, done_idx); end
        checks++;
        if (overlap) begin errors++; $display("FAIL %s busy_done_overlap got 1 want 0", name); end
        checks++;
        if (!held) begin errors++; $display("FAIL %s hold_during_run got changed want %0d/%0d", name, pd8, pb8); end
        checks++;
        if (got_d !== r[7:0]) begin errors++; $display("FAIL %s diff got %0d want %0d", name, got_d, r[7:0]); end
        checks++;
        if (got_b !== r[8]) begin errors++; $display("FAIL %s borrow got %0d want %0d", name, got_b, r[8]); end
        checks++;
        if (b8.diff !== r[7:0]) begin errors++; $display("FAIL %s diff_hold_after got %0d want %0d", name, b8.diff, r[7:0]); end
        pd8 = r[7:0];
        pb8 = r[8];
    endtask

    task automatic test_directed();
        op8(8'd200, 8'd55, -1, "200-55");
        op8(8'd55, 8'd200, -1, "55-200");
        op8(8'd0, 8'd1, -1, "0-1");
        op8(8'hAA, 8'hAA, -1, "AA-AA");
    endtask

    task automatic test_start_ignored();
        op8(8'd200, 8'd55, 3, "start_in_run");
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        b8.start = 1'b1; b8.a = 8'd200; b8.b = 8'd55;
        @(negedge clk);
        b8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({b8.busy, b8.done, b8.diff, b8.borrow_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_run got %b want 0", {b8.busy, b8.done, b8.diff, b8.borrow_out});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (b8.done !== 1'b0 || b8.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_held busy/done got %b%b want 00", b8.busy, b8.done);
            end
        end
        rst_n = 1'b1;
        pd8 = '0;
        pb8 = 1'b0;
        op8(8'd10, 8'd3, -1, "10-3_after_reset");
    endtask

    // start held high: second operation accepted on the first IDLE edge,
    // i.e. WIDTH+2 cycles after the first.
    task automatic test_back_to_back();
        logic [8:0] r1, r2;
        int         idx[$];
        logic [8:0] res[$];
        logic [7:0] x1, y1, x2, y2;
        x1 = 8'($urandom); y1 = 8'($urandom);
        x2 = 8'($urandom); y2 = 8'($urandom);
        r1 = {1'b0, x1} - {1'b0, y1};
        r2 = {1'b0, x2} - {1'b0, y2};
        @(negedge clk);
        b8.start = 1'b1; b8.a = x1; b8.b = y1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (b8.done) begin
                idx.push_back(i);
                res.push_back({b8.borrow_out, b8.diff});
            end
            if (i == 9) begin
                checks++;
                if (b8.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap busy got 1 want 0"); end
            end
            if (i == 8) begin b8.a = x2; b8.b = y2; end
            if (i == 10) b8.start = 1'b0;
        end
        checks++;
        if (idx.size() != 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d want 2", idx.size());
        end else begin
            checks++;
            if (idx[0] != 8 || idx[1] != 18) begin
                errors++;
                $display("FAIL b2b_done_cycles got %0d,%0d want 8,18", idx[0], idx[1]);
            end
            checks++;
            if (res[0] !== r1 || res[1] !== r2) begin
                errors++;
                $display("FAIL b2b_results got %h,%h want %h,%h", res[0], res[1], r1, r2);
            end
        end
        pd8 = r2[7:0];
        pb8 = r2[8];
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            op8(8'($urandom), 8'($urandom), -1, "random");
        end
    endtask

    task automatic test_width1();
        logic       x, y;
        logic [1:0] r;
        for (int v = 0; v < 4; v++) begin
            x = (v >= 2);
            y = (v % 2 == 1);
            r = {1'b0, x} - {1'b0, y};
            @(negedge clk);
            b1.start = 1'b1; b1.a = x; b1.b = y;
            @(negedge clk);
            b1.start = 1'b0;
            checks++;
            if (b1.busy !== 1'b1 || b1.done !== 1'b0) begin
                errors++;
                $display("FAIL w1_run busy/done got %b%b want 10", b1.busy, b1.done);
            end
            @(negedge clk);
            checks++;
            if (b1.busy !== 1'b0 || b1.done !== 1'b1) begin
                errors++;
                $display("FAIL w1_done busy/done got %b%b want 01", b1.busy, b1.done);
            end
            checks++;
            if ({b1.borrow_out, b1.diff} !== r) begin
                errors++;
                $display("FAIL w1_result a=%0d b=%0d got %b want %b", x, y, {b1.borrow_out, b1.diff}, r);
            end
            @(negedge clk);
            checks++;
            if (b1.done !== 1'b0) begin errors++; $display("FAIL w1_idle done got 1 want 0"); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial multi-bit subtractor controller. It computes `a - b` for WIDTH-bit unsigned operands by sequencing one one-bit subtract cell (two half-subtractor stages plus borrow-in) over WIDTH clock cycles, LSB first, and holds a registered borrow between bits. A start/busy/done handshake frames each operation. It is the sequential wrapper that lets the combinational half-subtractor datapath serve word-wide subtraction.

## Interface
- `WIDTH`, 8, operand and result width in bits; legal range 1..32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on the accepted start edge.
- `b`  in  WIDTH  subtrahend; captured on the accepted start edge.
- `busy`  out  1  high while state is RUN.
- `done`  out  1  one-cycle pulse while state is DONE.
- `diff`  out  WIDTH  result `(a - b) mod 2^WIDTH`; registered.
- `borrow_out`  out  1  final borrow; 1 exactly when a < b (unsigned); registered.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when `start`=1.
  - RUN→DONE when the bit counter reaches WIDTH-1 and that bit is processed.
  - DONE→IDLE unconditionally.
- Accepted start: load shift registers `sa`←`a` and `sb`←`b`; clear the borrow flop `bq` to 0; clear the bit counter to 0.
- Each RUN cycle processes the current LSBs `x`=`sa[0]`, `y`=`sb[0]`, `bi`=`bq`.
  - Stage 1: `d1`=`x^y` and `b1`=`~x&y`.
  - Stage 2: `d`=`d1^bi` and `b2`=`~d1&bi`.
  - Update: `bq`←`b1|b2`; `sa` and `sb` shift right; `d` shifts into the MSB of the result shift register `sr`; the counter increments.
- On the RUN→DONE edge:
  - `diff`←final `sr`, including the last bit.
  - `borrow_out`←final borrow.
- `diff` and `borrow_out` hold their values until the next RUN→DONE edge. They are not cleared by `start`.
- `start` is ignored in RUN and DONE; it is not queued. Operands changing during RUN have no effect.
- Counter width: `$clog2(WIDTH+1)`. With WIDTH=1 the FSM goes IDLE→RUN→DONE, processing one bit.

## Timing
- Reset (async assert, any state): state=IDLE; `busy`=0, `done`=0, `diff`=0, `borrow_out`=0; `sa`, `sb`, `sr`, `bq` and the counter are all 0.
- Reset deassertion: the first rising edge with `rst_n`=1 may accept `start`.
- Reset mid-RUN aborts the operation. No `done` is produced, and outputs go to their reset values.
- Cycle numbering: the accepting edge is E0.
  - `busy`=1 after E0 through E_WIDTH, i.e. WIDTH cycles.
  - Bit i is computed in the cycle after E_i and registered at E_(i+1).
  - At E_WIDTH: state=DONE, `busy`=0, `done`=1, `diff` and `borrow_out` are valid.
  - At E_(WIDTH+1): state=IDLE, `done`=0.
- Latency: start edge to `done` high = WIDTH cycles. Minimum start-to-start spacing = WIDTH+2 cycles. A `start` held high re-triggers on the first IDLE edge.
- `busy` and `done` are never high together. Both are decoded from state only.

## Test plan
- WIDTH=8, a=200, b=55, start pulse → `busy` high for 8 cycles, then `done` for 1 cycle; `diff`=145, `borrow_out`=0.
- a=55, b=200 → `diff`=111 (8'h6F), `borrow_out`=1. Then a=0, b=1 → `diff`=8'hFF, `borrow_out`=1.
- a=b=8'hAA → `diff`=0, `borrow_out`=0. Verify the previous result stays held until this `done`.
- Pulse `start` with a=3, b=1 while `busy` at cycle 4 of a 200-55 operation → exactly one `done`, result 145; no second operation starts.
- Assert `rst_n`=0 mid-RUN (cycle 3) → all outputs 0 immediately, no `done`. After release, a=10, b=3 → `diff`=7 after 8 cycles.
- WIDTH=1 instance, all four {a,b} combos → (0,0)→0/0, (0,1)→1/1, (1,0)→1/0, (1,1)→0/0. `done` follows start by 1 cycle.
